pmem_line_responder: RTL and testbench
======================================

// Module: pmem_line_responder
// PURPOSE
//  Synthesizable physical-memory responder: the memory end of the pmem
//  interface driven by the cache's pmem address/datapath logic. Accepts
//  32-byte line reads and writes (pmem_read/pmem_write, pmem_address,
//  pmem_wdata) and returns pmem_resp after a programmable latency, with
//  pmem_rdata on reads. Replaces the behavioural memory model on the bench.
// PARAMETERS
//  LATENCY         10  BUSY cycles per transaction; legal range 1..255
//  LINE_IDX_WIDTH  8   log2(lines stored); 8 -> 256 lines = 8 KiB
// PORTS
//  clk             in   1    clock, all state on rising edge
//  rst             in   1    synchronous, active-high reset
//  pmem_read       in   1    line read request, level
//  pmem_write      in   1    line write request, level
//  pmem_address    in   32   byte address; [4:0] offset, [4+IDX:5] line index
//  pmem_wdata      in   256  write line, sampled at acceptance
//  pmem_rdata      out  256  read line, valid in pmem_resp cycle, held after
//  pmem_resp       out  1    one-cycle completion pulse
//  pmem_busy       out  1    high while a transaction is in flight
//  pmem_error      out  1    sticky protocol-error flag
// BEHAVIOUR
//  Clock is clk; reset is rst, synchronous and active-high.
//  Reset: state IDLE, pmem_resp=0, pmem_rdata=0, pmem_busy=0, pmem_error=0,
//   counter=0. Storage array is NOT reset; its contents survive rst.
//  FSM IDLE -> BUSY -> RESP -> IDLE.
//   IDLE: if pmem_read|pmem_write, latch op, line index, wdata;
//    counter<=LATENCY-1; ->BUSY. Otherwise stay. pmem_busy=0.
//   BUSY: pmem_busy=1; counter decrements each cycle. At counter==0:
//    write -> array[idx]<=latched wdata; read -> pmem_rdata<=array[idx];
//    ->RESP.
//   RESP: pmem_resp=1, pmem_busy=1, exactly one cycle; ->IDLE.
//  Timing: request seen in IDLE in cycle 0 -> BUSY cycles 1..LATENCY ->
//   pmem_resp high in cycle LATENCY+1. No pipelining; one outstanding txn.
//  Inputs are ignored outside IDLE; dropping or changing requests during
//   BUSY does not affect the latched transaction.
//  A request still asserted in the IDLE cycle after RESP is a new
//   transaction (back-to-back supported, LATENCY+2 cycle period).
//  pmem_read & pmem_write together: write executed, pmem_error<=1.
//  pmem_address[4:0] != 0 at acceptance: offset ignored (line-aligned
//   access), pmem_error<=1. Address bits above the index alias.
//  pmem_error clears only on rst.
//  pmem_rdata updates only on read completion; writes leave it unchanged.
//  Read after write to the same line returns the new data (write commits
//   at BUSY exit, before any later acceptance).
//  rst during BUSY/RESP: abort, return to IDLE, no array write, no resp.
// STRUCTURE
//  Package pmem_pkg: PMEM_OFFSET_WIDTH=5, PMEM_LINE_WIDTH=256,
//   PMEM_ADDR_WIDTH=32, typedef pmem_line_t logic[255:0],
//   enum pmem_state_t {PMEM_IDLE, PMEM_BUSY, PMEM_RESP}.
//  Sub-module pmem_line_array: 2^LINE_IDX_WIDTH x 256 storage, one
//   synchronous write port, one synchronous read port; no reset.
//  Top holds FSM, latency counter, request latches, error flag.
// TESTING
//  T1 LATENCY=10: write line 0x1234_5660 data {8{32'hDEAD_BEEF}}, then read
//   same addr -> resp exactly 11 cycles after each acceptance, rdata match.
//  T2 Back-to-back: hold pmem_read at 0x0000_0020 through resp -> second
//   resp 12 cycles after first; pmem_busy low only in the IDLE cycle between.
//  T3 Drop pmem_read in cycle 3 of BUSY -> resp still in cycle LATENCY+1,
//   rdata = stored line.
//  T4 read&write together at 0x40, wdata=256'h1 -> pmem_error=1, later read
//   of 0x40 returns 256'h1; addr 0x45 read -> returns line 0x40, error held.
//  T5 rst asserted in BUSY cycle 5 of a write of 256'hAA.. to 0x80 -> no
//   resp, outputs at reset values, later read of 0x80 returns prior contents.
//  T6 LATENCY=1: write/read pair -> resp in cycle 2 after each acceptance.

Source files
------------

// File: rtl/pmem_pkg.sv
// -----------------------------------------------------------------------------
// pmem_pkg
// Shared types and constants for the physical-memory line responder.
//   PMEM_OFFSET_WIDTH : byte-offset bits inside a 32-byte line
//   PMEM_LINE_WIDTH   : bits per line
//   PMEM_ADDR_WIDTH   : byte-address width on the pmem interface
//   PMEM_CNT_WIDTH    : latency counter width (LATENCY is 1..255)
//   pmem_line_t       : one 256-bit line
//   pmem_state_t      : responder FSM states
// -----------------------------------------------------------------------------
package pmem_pkg;

    localparam int PMEM_OFFSET_WIDTH = 5;
    localparam int PMEM_LINE_WIDTH   = 256;
    localparam int PMEM_ADDR_WIDTH   = 32;
    localparam int PMEM_CNT_WIDTH    = 8;

    typedef logic [PMEM_LINE_WIDTH-1:0] pmem_line_t;

    typedef enum logic [1:0] {
        PMEM_IDLE = 2'd0,
        PMEM_BUSY = 2'd1,
        PMEM_RESP = 2'd2
    } pmem_state_t;

    // A non-zero byte offset means the requester is not line-aligned.
    function automatic logic pmem_misaligned(input logic [PMEM_ADDR_WIDTH-1:0] addr);
        return addr[PMEM_OFFSET_WIDTH-1:0] != '0;
    endfunction

endpackage

// File: rtl/pmem_line_array.sv
// -----------------------------------------------------------------------------
// pmem_line_array
// Line storage: 2^LINE_IDX_WIDTH lines of 256 bits. One synchronous write
// port and one synchronous read port. No reset: contents survive rst.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_idx   in   line index for the write
//   wr_data  in   line written
//   rd_idx   in   line index for the read
//   rd_data  out  registered read data (mem[rd_idx] of the previous cycle)
// -----------------------------------------------------------------------------
module pmem_line_array
    import pmem_pkg::*;
#(
    parameter int LINE_IDX_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [LINE_IDX_WIDTH-1:0] wr_idx,
    input  pmem_line_t                wr_data,
    input  logic [LINE_IDX_WIDTH-1:0] rd_idx,
    output pmem_line_t                rd_data
);

    localparam int DEPTH = 1 << LINE_IDX_WIDTH;

    pmem_line_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/pmem_line_responder.sv
// -----------------------------------------------------------------------------
// pmem_line_responder
// Memory end of the cache pmem interface. Accepts one 32-byte line read or
// write at a time and completes it LATENCY busy cycles later with a one-cycle
// pmem_resp pulse (pmem_rdata valid in that cycle for reads, held afterwards).
//
// Handshake: pmem_read/pmem_write are levels. A request is accepted in any
// IDLE cycle where either is high; address and wdata are captured at that
// edge and all inputs are ignored until the FSM is back in IDLE. Completion
// is the single pmem_resp cycle; a request still high in the following IDLE
// cycle starts a new transaction.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset (storage not reset)
//   pmem_read     in   line read request
//   pmem_write    in   line write request
//   pmem_address  in   byte address, [4:0] offset, [4+IDX:5] line index
//   pmem_wdata    in   write line, captured at acceptance
//   pmem_rdata    out  read line, updated on read completion only
//   pmem_resp     out  one-cycle completion pulse
//   pmem_busy     out  high while a transaction is in flight
//   pmem_error    out  sticky protocol error (read+write, or misaligned)
//   dbg_state     out  current FSM state
// -----------------------------------------------------------------------------
module pmem_line_responder
    import pmem_pkg::*;
#(
    parameter int LATENCY        = 10,
    parameter int LINE_IDX_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pmem_read,
    input  logic                       pmem_write,
    input  logic [PMEM_ADDR_WIDTH-1:0] pmem_address,
    input  pmem_line_t                 pmem_wdata,
    output pmem_line_t                 pmem_rdata,
    output logic                       pmem_resp,
    output logic                       pmem_busy,
    output logic                       pmem_error,
    output pmem_state_t                dbg_state
);

    localparam logic [PMEM_CNT_WIDTH-1:0] CNT_LOAD = PMEM_CNT_WIDTH'(LATENCY - 1);
    localparam int IDX_TOP = PMEM_OFFSET_WIDTH + LINE_IDX_WIDTH;

    pmem_state_t                state;
    pmem_state_t                state_next;
    logic [PMEM_CNT_WIDTH-1:0]  cnt;
    logic                       op_write_q;
    logic [LINE_IDX_WIDTH-1:0]  idx_q;
    pmem_line_t                 wdata_q;
    logic                       accept;
    logic                       commit;
    logic [LINE_IDX_WIDTH-1:0]  req_idx;
    logic [LINE_IDX_WIDTH-1:0]  rd_idx;
    logic                       arr_wr_en;
    pmem_line_t                 arr_rd_data;

    // Address bits above the line index alias onto the same lines.
    logic unused_addr_high;
    assign unused_addr_high = ^pmem_address[PMEM_ADDR_WIDTH-1:IDX_TOP];

    assign req_idx   = pmem_address[PMEM_OFFSET_WIDTH +: LINE_IDX_WIDTH];
    assign dbg_state = state;

    // In IDLE the read port follows the incoming address so the line is
    // already sitting in arr_rd_data by the first BUSY cycle; this keeps
    // LATENCY=1 working. Afterwards it stays on the latched index.
    assign rd_idx = (state == PMEM_IDLE) ? req_idx : idx_q;

    // The write lands at BUSY exit, before any later acceptance can read it.
    assign arr_wr_en = commit && op_write_q && !rst;

    pmem_line_array #(
        .LINE_IDX_WIDTH (LINE_IDX_WIDTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_wr_en),
        .wr_idx  (idx_q),
        .wr_data (wdata_q),
        .rd_idx  (rd_idx),
        .rd_data (arr_rd_data)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PMEM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and outputs
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        commit     = 1'b0;
        pmem_busy  = 1'b0;
        pmem_resp  = 1'b0;
        case (state)
            PMEM_IDLE: begin
                if (pmem_read || pmem_write) begin
                    accept     = 1'b1;
                    state_next = PMEM_BUSY;
                end
            end
            PMEM_BUSY: begin
                pmem_busy = 1'b1;
                if (cnt == '0) begin
                    commit     = 1'b1;
                    state_next = PMEM_RESP;
                end
            end
            PMEM_RESP: begin
                pmem_busy  = 1'b1;
                pmem_resp  = 1'b1;
                state_next = PMEM_IDLE;
            end
            default: begin
                state_next = PMEM_IDLE;
            end
        endcase
    end

    // Request latches, latency counter, read data and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            pmem_rdata <= '0;
            pmem_error <= 1'b0;
        end else begin
            if (accept) begin
                // Simultaneous read+write is executed as a write.
                op_write_q <= pmem_write;
                idx_q      <= req_idx;
                wdata_q    <= pmem_wdata;
                cnt        <= CNT_LOAD;
                if ((pmem_read && pmem_write) || pmem_misaligned(pmem_address)) begin
                    pmem_error <= 1'b1;
                end
            end else if (state == PMEM_BUSY && cnt != '0) begin
                cnt <= cnt - PMEM_CNT_WIDTH'(1);
            end

            if (commit && !op_write_q) begin
                pmem_rdata <= arr_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_pmem_line_responder.sv
// -----------------------------------------------------------------------------
// tb_pmem_line_responder
// Two responders (LATENCY=10 and LATENCY=1) share clock, reset and request
// buses; sel steers the request strobes to one of them and picks which
// outputs are observed. Expected values come from a line-array model.
// -----------------------------------------------------------------------------
module tb_pmem_line_responder;
    import pmem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    pmem_line_t  pmem_wdata;
    logic        sel;

    pmem_line_t  rdata10, rdata1;
    logic        resp10, resp1, busy10, busy1, err10, err1;
    pmem_state_t st10, st1;

    pmem_line_t  rdata_s;
    logic        resp_s, busy_s, error_s;

    assign rdata_s = sel ? rdata1 : rdata10;
    assign resp_s  = sel ? resp1  : resp10;
    assign busy_s  = sel ? busy1  : busy10;
    assign error_s = sel ? err1   : err10;

    pmem_line_responder #(.LATENCY(10), .LINE_IDX_WIDTH(8)) dut10 (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read & ~sel),
        .pmem_write   (pmem_write & ~sel),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (rdata10),
        .pmem_resp    (resp10),
        .pmem_busy    (busy10),
        .pmem_error   (err10),
        .dbg_state    (st10)
    );

    pmem_line_responder #(.LATENCY(1), .LINE_IDX_WIDTH(8)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read & sel),
        .pmem_write   (pmem_write & sel),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (rdata1),
        .pmem_resp    (resp1),
        .pmem_busy    (busy1),
        .pmem_error   (err1),
        .dbg_state    (st1)
    );

    // ---------------- scoreboard ----------------
    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // ---------------- reference model ----------------
    pmem_line_t mem_m   [2][256];
    bit         known_m [2][256];
    pmem_line_t rd_m    [2];
    bit         rdk_m   [2];
    bit         err_m   [2];

    function automatic int lat_of(input int d);
        return (d == 1) ? 1 : 10;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            rd_m[d]  = '0;
            rdk_m[d] = 1'b1;
            err_m[d] = 1'b0;
        end
    endfunction

    function automatic void model_step(input int d, input bit rd, input bit wr,
                                       input logic [31:0] addr, input pmem_line_t wd);
        int idx;
        idx = int'(addr[12:5]);
        if ((rd && wr) || addr[4:0] != 5'd0) err_m[d] = 1'b1;
        if (wr) begin
            mem_m[d][idx]   = wd;
            known_m[d][idx] = 1'b1;
        end else if (rd) begin
            rd_m[d]  = mem_m[d][idx];
            rdk_m[d] = known_m[d][idx];
        end
    endfunction

    function automatic pmem_line_t rand_line();
        pmem_line_t l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge in an IDLE cycle (cycle 0). Returns the cycle in
    // which pmem_resp was seen, plus rdata/error sampled in that cycle.
    task automatic apply(input bit rd, input bit wr, input logic [31:0] addr,
                         input pmem_line_t wd, output int lat,
                         output pmem_line_t rdat, output bit err);
        int nb;
        nb   = 0;
        lat  = -1;
        rdat = '0;
        err  = 1'b0;
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 1) begin
                pmem_read    = 1'b0;
                pmem_write   = 1'b0;
                pmem_address = $urandom;
                pmem_wdata   = rand_line();
            end
            if (!busy_s) nb++;
            if (resp_s) begin
                lat  = n;
                rdat = rdata_s;
                err  = error_s;
                break;
            end
        end
        check("busy_in_flight_low_cycles", nb, 0);
        @(negedge clk);
        check("busy_after_resp", busy_s, 1'b0);
    endtask

    task automatic txn_check(input string tag, input bit rd, input bit wr,
                             input logic [31:0] addr, input pmem_line_t wd);
        int lat;
        pmem_line_t rdat;
        bit err;
        int d;
        d = sel ? 1 : 0;
        apply(rd, wr, addr, wd, lat, rdat, err);
        model_step(d, rd, wr, addr, wd);
        check({tag, " latency"}, lat, lat_of(d) + 1);
        if (rdk_m[d]) check({tag, " rdata"}, rdat, rd_m[d]);
        check({tag, " error"}, err, err_m[d]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " resp10"},  resp10,  1'b0);
        check({tag, " busy10"},  busy10,  1'b0);
        check({tag, " error10"}, err10,   1'b0);
        check({tag, " rdata10"}, rdata10, '0);
        check({tag, " state10"}, st10,    PMEM_IDLE);
        check({tag, " resp1"},   resp1,   1'b0);
        check({tag, " busy1"},   busy1,   1'b0);
        check({tag, " error1"},  err1,    1'b0);
        check({tag, " rdata1"},  rdata1,  '0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        pmem_line_t  wdata;
        pmem_line_t  exp_rdata;
        bit          exp_error;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, r1, r2, low, idx;
        pmem_line_t rdat, rd1, rd2, pat;
        bit err;
        logic [31:0] a;

        pmem_read = 0; pmem_write = 0; pmem_address = 0; pmem_wdata = '0; sel = 0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) begin mem_m[d][i] = '0; known_m[d][i] = 0; end
        model_reset();

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // T1 / T4 plus aliasing, table driven on the LATENCY=10 instance
        vecs[0] = '{"t1_write", 0, 1, 32'h1234_5660, {8{32'hDEAD_BEEF}}, '0, 0};
        vecs[1] = '{"t1_read", 1, 0, 32'h1234_5660, '0, {8{32'hDEAD_BEEF}}, 0};
        vecs[2] = '{"t4_rdwr", 1, 1, 32'h0000_0040, 256'h1, {8{32'hDEAD_BEEF}}, 1};
        vecs[3] = '{"t4_read40", 1, 0, 32'h0000_0040, '0, 256'h1, 1};
        vecs[4] = '{"t4_read45", 1, 0, 32'h0000_0045, '0, 256'h1, 1};
        vecs[5] = '{"alias_read", 1, 0, 32'hFFFF_F660, '0, {8{32'hDEAD_BEEF}}, 1};
        for (int v = 0; v < 6; v++) begin
            apply(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, lat, rdat, err);
            model_step(0, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
            check({vecs[v].name, " latency"}, lat, 11);
            check({vecs[v].name, " rdata"}, rdat, vecs[v].exp_rdata);
            check({vecs[v].name, " error"}, err, vecs[v].exp_error);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 16; i++)
            txn_check("fill", 0, 1, 32'(i) << 5, rand_line());
        for (int i = 0; i < 30; i++) begin
            int op;
            idx = $urandom_range(0, 15);
            a = (32'($urandom_range(0, 7)) << 13) | (32'(idx) << 5);
            if ($urandom_range(0, 7) == 0) a[4:0] = 5'($urandom_range(1, 31));
            op = $urandom_range(0, 9);
            txn_check("rand", op < 5 || op == 9, op >= 5, a, rand_line());
        end

        // T2 back-to-back reads held through resp
        r1 = -1; r2 = -1; low = 0; rd1 = '0; rd2 = '0;
        pmem_read = 1'b1; pmem_address = 32'h0000_0020;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (resp_s) begin
                if (r1 < 0) begin
                    r1 = n; rd1 = rdata_s;
                end else begin
                    r2 = n; rd2 = rdata_s; pmem_read = 1'b0;
                    break;
                end
            end else if (!busy_s) begin
                low++;
            end
        end
        pmem_read = 1'b0;
        @(negedge clk);
        model_step(0, 1, 0, 32'h20, '0);
        model_step(0, 1, 0, 32'h20, '0);
        check("t2 first latency", r1, 11);
        check("t2 resp period", r2 - r1, 12);
        check("t2 busy low cycles", low, 1);
        check("t2 rdata first", rd1, rd_m[0]);
        check("t2 rdata second", rd2, rd_m[0]);

        // T3 drop the request in BUSY cycle 3
        lat = -1; rdat = '0;
        pmem_read = 1'b1; pmem_address = 32'h0000_0060;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 3) begin
                pmem_read = 1'b0; pmem_address = 32'h0000_1FE0; pmem_wdata = rand_line();
            end
            if (resp_s) begin lat = n; rdat = rdata_s; break; end
        end
        pmem_read = 1'b0;
        @(negedge clk);
        model_step(0, 1, 0, 32'h60, '0);
        check("t3 latency", lat, 11);
        check("t3 rdata", rdat, rd_m[0]);

        // T5 reset in BUSY cycle 5 of a write to 0x80
        pat = {32{8'hAA}};
        pmem_write = 1'b1; pmem_address = 32'h0000_0080; pmem_wdata = pat;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) begin pmem_write = 1'b0; pmem_address = 0; end
        end
        check("t5 busy before rst", busy10, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_outputs("t5 after rst");
        low = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (resp10) low++;
        end
        check("t5 no resp after abort", low, 0);
        txn_check("t5 read80", 1, 0, 32'h0000_0080, '0);

        // T6 LATENCY=1 instance
        sel = 1'b1;
        @(negedge clk);
        pat = rand_line();
        txn_check("t6 write", 0, 1, 32'h0000_0100, pat);
        txn_check("t6 read", 1, 0, 32'h0000_0100, '0);
        check("t6 read data", rd_m[1], pat);
        txn_check("t6 misaligned read", 1, 0, 32'h0000_010F, '0);
        txn_check("t6 write other", 0, 1, 32'h0000_0120, rand_line());
        txn_check("t6 read other", 1, 0, 32'h0000_0120, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
